// File: rtl/conv2_sum_collector.sv
// conv2_sum_collector: bias, ReLU and saturate conv-2 sums into a valid/ready FIFO with frame counting
module conv2_sum_collector #(
  parameter int IN_W        = 18,
  parameter int OUT_W       = 16,
  parameter int BIAS_W      = 16,
  parameter int DEPTH       = 4,
  parameter int NUM_RESULTS = 16,
  parameter bit RELU_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [IN_W-1:0]   sum_in,
  input  logic              sum_done,
  input  logic [BIAS_W-1:0] bias,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              frame_done,
  output logic              overflow,
  input  logic              clear_overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = IN_W + 1;
  localparam int CW = $clog2(NUM_RESULTS + 1);
  localparam logic signed [SW-1:0] MAX_V = SW'((2 ** (OUT_W - 1)) - 1);
  localparam logic signed [SW-1:0] MIN_V = -MAX_V - SW'(1);
  logic signed [SW-1:0] s;
  logic [OUT_W-1:0] sat, stage_data;
  logic stage_valid;
  logic [OUT_W-1:0] mem [DEPTH];
  logic [AW:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic full, empty, pop, push, drop;
  assign s = $signed({{(SW-IN_W){sum_in[IN_W-1]}}, sum_in}) + $signed({{(SW-BIAS_W){bias[BIAS_W-1]}}, bias});
  assign empty = wptr == rptr;
  assign full = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign out_valid = !empty;
  assign out_data = empty ? '0 : mem[rptr[AW-1:0]];
  assign pop = out_valid & out_ready;
  assign push = stage_valid & (!full | pop);
  assign drop = stage_valid & full & !pop;
  // Clamp the 19-bit biased sum into the output range, flooring at zero under ReLU
  always_comb
    sat = (RELU_EN && s[SW-1]) ? '0 : (s > MAX_V) ? MAX_V[OUT_W-1:0] : (s < MIN_V) ? MIN_V[OUT_W-1:0] : s[OUT_W-1:0];
  // Stage register, FIFO pointers, frame counter and sticky overflow
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      stage_valid <= 1'b0;
      stage_data  <= '0;
      wptr        <= '0;
      rptr        <= '0;
      cnt         <= '0;
      frame_done  <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      stage_valid <= sum_done;
      stage_data  <= sum_done ? sat : stage_data;
      wptr        <= push ? wptr + (AW+1)'(1) : wptr;
      rptr        <= pop ? rptr + (AW+1)'(1) : rptr;
      cnt         <= stage_valid ? (cnt == CW'(NUM_RESULTS - 1) ? '0 : cnt + CW'(1)) : cnt;
      frame_done  <= stage_valid && cnt == CW'(NUM_RESULTS - 1);
      overflow    <= drop ? 1'b1 : clear_overflow ? 1'b0 : overflow;
    end
  // FIFO storage needs no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk)
    if (push) mem[wptr[AW-1:0]] <= stage_data;
endmodule

// File: tb/tb_conv2_sum_collector.sv
// tb_conv2_sum_collector: randomized and directed scoreboard bench for conv2_sum_collector
module tb_conv2_sum_collector;
  localparam int DEPTH = 4;
  localparam int NUM = 16;
  logic clk = 1'b0;
  logic reset_n;
  logic signed [17:0] sum_in;
  logic signed [15:0] bias;
  logic sum_done, out_ready, clear_overflow;
  logic [15:0] d1, d0;
  logic v1, v0, fd1, fd0, ov1, ov0;
  int vectors = 0;
  int miscompares = 0;
  int q1[$];
  int q0[$];
  bit pend;
  int p1, p0;
  bit m_ovf, m_fd;
  int m_cnt;

  always #5 clk = ~clk;

  conv2_sum_collector #(.RELU_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .sum_in(sum_in), .sum_done(sum_done), .bias(bias),
    .out_data(d1), .out_valid(v1), .out_ready(out_ready), .frame_done(fd1),
    .overflow(ov1), .clear_overflow(clear_overflow)
  );
  conv2_sum_collector #(.RELU_EN(1'b0)) dut_n (
    .clk(clk), .reset_n(reset_n), .sum_in(sum_in), .sum_done(sum_done), .bias(bias),
    .out_data(d0), .out_valid(v0), .out_ready(out_ready), .frame_done(fd0),
    .overflow(ov0), .clear_overflow(clear_overflow)
  );

  function automatic int calc(input int s_in, input int b, input bit relu);
    int s;
    s = s_in + b;
    if (relu && s < 0) s = 0;
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
    return s;
  endfunction

  task automatic chk(input string n, input int a, input int e);
    vectors++;
    if (a != e) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", n, a, e, $time);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Reference model: result queues with a one-cycle capture stage ahead of them
  always @(posedge clk or negedge reset_n) begin
    bit pop, drop;
    if (!reset_n) begin
      q1.delete(); q0.delete();
      pend = 0; m_ovf = 0; m_fd = 0; m_cnt = 0;
    end else begin
      pop = q1.size() > 0 && out_ready;
      drop = 0;
      if (pop) begin
        void'(q1.pop_front());
        void'(q0.pop_front());
      end
      if (pend) begin
        if (q1.size() < DEPTH) begin
          q1.push_back(p1);
          q0.push_back(p0);
        end else drop = 1;
      end
      m_ovf = drop ? 1'b1 : clear_overflow ? 1'b0 : m_ovf;
      m_fd = pend && m_cnt == NUM - 1;
      if (pend) m_cnt = (m_cnt + 1) % NUM;
      pend = sum_done;
      p1 = calc(int'(sum_in), int'(bias), 1'b1);
      p0 = calc(int'(sum_in), int'(bias), 1'b0);
    end
  end

  // Monitor: compare both DUTs against the model heads away from the clock edge
  always @(negedge clk) begin
    chk("valid_relu", int'(v1), int'(q1.size() > 0));
    chk("valid_signed", int'(v0), int'(q0.size() > 0));
    chk("data_relu", int'($signed(d1)), q1.size() > 0 ? q1[0] : 0);
    chk("data_signed", int'($signed(d0)), q0.size() > 0 ? q0[0] : 0);
    chk("overflow", int'(ov1), int'(m_ovf));
    chk("overflow_signed", int'(ov0), int'(m_ovf));
    chk("frame_done", int'(fd1), int'(m_fd));
    chk("frame_done_signed", int'(fd0), int'(m_fd));
  end

  task automatic one(input int s, input int b, input int e1, input int e0);
    sum_in = 18'(s); bias = 16'(b); sum_done = 1; step;
    sum_done = 0; step;
    chk("one_valid", int'(v1), 1);
    chk("one_data_relu", int'($signed(d1)), e1);
    chk("one_data_signed", int'($signed(d0)), e0);
    step;
  endtask

  initial begin
    reset_n = 0; sum_in = 0; bias = 0; sum_done = 0; out_ready = 0; clear_overflow = 0;
    repeat (2) step;
    chk("rst_valid", int'(v1), 0);
    chk("rst_data", int'(d1), 0);
    chk("rst_overflow", int'(ov1), 0);
    chk("rst_frame_done", int'(fd1), 0);
    reset_n = 1;
    step;
    out_ready = 1; sum_in = 1000; bias = 5; sum_done = 1; step;
    sum_done = 0;
    chk("lat_early", int'(v1), 0);
    step;
    chk("lat_valid", int'(v1), 1);
    chk("lat_data", int'($signed(d1)), 1005);
    step;
    chk("pop_valid", int'(v1), 0);
    chk("pop_data", int'(d1), 0);
    one(131071, 100, 32767, 32767);
    one(-131072, -1, 0, -32768);
    one(-200, 50, 0, -150);
    out_ready = 0;
    for (int i = 1; i <= 6; i++) begin
      sum_in = 18'(i); bias = 0; sum_done = 1; step;
    end
    sum_done = 0;
    chk("ovf_set", int'(ov1), 1);
    step;
    chk("ovf_hold", int'(ov1), 1);
    out_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      chk("drain", int'($signed(d1)), i);
      step;
    end
    chk("drain_empty", int'(v1), 0);
    clear_overflow = 1; step;
    clear_overflow = 0;
    chk("ovf_clear", int'(ov1), 0);
    out_ready = 0;
    for (int i = 0; i < 5; i++) begin
      sum_in = 18'(11 + i); sum_done = 1; step;
    end
    sum_done = 0; out_ready = 1; step;
    chk("full_pushpop_ovf", int'(ov1), 0);
    for (int i = 12; i <= 15; i++) begin
      chk("full_order", int'($signed(d1)), i);
      step;
    end
    chk("full_empty", int'(v1), 0);
    reset_n = 0; step;
    reset_n = 1;
    for (int i = 0; i < 17; i++) begin
      sum_in = 18'($urandom_range(0, 2000)); sum_done = 1; step;
      if (i < 15) chk("frame_early", int'(fd1), 0);
    end
    chk("frame_pulse", int'(fd1), 1);
    sum_done = 0; step;
    chk("frame_17th", int'(fd1), 0);
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      sum_in = 18'(i); sum_done = 1; step;
    end
    reset_n = 0; #1;
    chk("midrst_valid", int'(v1), 0);
    chk("midrst_data", int'(d1), 0);
    step;
    reset_n = 1; out_ready = 1;
    for (int i = 0; i < 15; i++) begin
      sum_in = 18'(i); sum_done = 1; step;
    end
    sum_done = 0; step;
    chk("restart_15", int'(fd1), 0);
    sum_done = 1; step;
    sum_done = 0; step;
    chk("restart_16", int'(fd1), 1);
    repeat (500) begin
      sum_done = $urandom_range(0, 3) != 0;
      sum_in = 18'($urandom);
      bias = 16'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      clear_overflow = $urandom_range(0, 7) == 0;
      step;
    end
    sum_done = 0; out_ready = 1; clear_overflow = 0;
    repeat (8) step;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
